fetch_unit: RTL and testbench
=============================

FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter RESET_PC, default 8'h00: PC value loaded on reset.
REQ-002 clk  input  1  single clock; all state on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 mem_addr  output  8  read address to the 256x8 synchronous memory.
REQ-005 mem_we  output  1  memory write enable; constant 0.
REQ-006 mem_rdata  input  8  memory read data, valid the cycle after mem_addr is presented.
REQ-007 redirect  input  1  branch/jump request, takes priority over all other activity.
REQ-008 redirect_pc  input  8  new PC, sampled when redirect=1.
REQ-009 instr_valid  output  1  assembled instruction available.
REQ-010 instr_ready  input  1  decode stage accepts instruction.
REQ-011 instr_opcode  output  8  opcode byte.
REQ-012 instr_operand  output  8  operand byte; 8'h00 for one-byte instructions.
REQ-013 instr_pc  output  8  address of the opcode byte.

Function
REQ-014 The block SHALL use states FETCH, OPCODE, OPERAND and HOLD.
REQ-015 FETCH: mem_addr=pc; next state OPCODE.
REQ-016 OPCODE: capture mem_rdata into instr_opcode and instr_pc=pc. Drive mem_addr=pc+1. If opcode[7]=1, go to OPERAND; else instr_operand=8'h00, pc+=1, go to HOLD.
REQ-017 OPERAND: capture mem_rdata into instr_operand, pc+=2, go to HOLD.
REQ-018 HOLD: instr_valid=1. The transfer occurs on the edge where instr_valid&&instr_ready=1, then go to FETCH.
REQ-019 Latency from entering FETCH to instr_valid=1: 2 cycles for one-byte instructions, 3 cycles for two-byte instructions. Max throughput: one instruction per 3 (one-byte) or 4 (two-byte) cycles.
REQ-020 instr_opcode, instr_operand and instr_pc SHALL hold stable while instr_valid=1 and no transfer or redirect has occurred.
REQ-021 PC arithmetic is modulo 256. A two-byte instruction at 8'hFF reads its operand at 8'h00. The next pc after it is 8'h01.
REQ-022 redirect=1 in any state: pc<=redirect_pc, state<=FETCH, instr_valid<=0 on the next edge; any in-flight capture is discarded.
REQ-023 redirect and transfer in the same cycle: the transfer counts as completed, and the redirect is applied.
REQ-024 mem_addr in HOLD SHALL equal pc, with no side effect.

Reset
REQ-025 rst_n=0 SHALL immediately force: state=FETCH, pc=RESET_PC, instr_valid=0, instr_opcode=8'h00, instr_operand=8'h00, instr_pc=8'h00.
REQ-026 Reset asserted mid-instruction SHALL discard partial captures. After release, fetching restarts at RESET_PC on the first clock edge.

Configuration
REQ-027 Macro FETCH_PERF_EN, when defined, SHALL add output instr_count (16 bits). It resets to 0, increments on each transfer, and saturates at 16'hFFFF.
REQ-028 Without FETCH_PERF_EN, the port and counter SHALL be absent, with no other behavioural change.

Structure
REQ-029 Shared package fetch_pkg SHALL hold the state enum, the two-byte indicator bit index (7) and the default RESET_PC constant.
REQ-030 No sub-module; the FSM, PC and output registers SHALL be in one module, connected externally to the 256x8 memory.

Verification
REQ-031 Memory holds 00:8'h01, 01:8'h02, idle ready=1 -> valid with opcode 01, pc 00, operand 00; then opcode 02, pc 01.
REQ-032 Memory holds 00:8'h85, 01:8'hAA -> valid with opcode 85, operand AA, pc 00; next fetch at 02; valid at 3 cycles after FETCH.
REQ-033 instr_ready=0 for 5 cycles in HOLD -> outputs unchanged and valid held; ready=1 -> one transfer only.
REQ-034 RESET_PC=8'hFF, FF:8'h90, 00:8'h11 -> opcode 90, operand 11, pc FF; next opcode fetched from 01.
REQ-035 redirect=1, redirect_pc=8'h40 in OPERAND, and separately with valid&&ready -> next valid has pc 40; the partial instruction is never presented; with FETCH_PERF_EN, instr_count increments only for completed transfers.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared types and constants for the byte-stream instruction fetch unit.
// Holds the FSM state enum, the two-byte indicator bit index and reset PC.
package fetch_pkg;

  typedef enum logic [1:0] {
    S_FETCH   = 2'd0,
    S_OPCODE  = 2'd1,
    S_OPERAND = 2'd2,
    S_HOLD    = 2'd3
  } fetch_state_t;

  localparam int unsigned TWO_BYTE_BIT = 7;

  localparam logic [7:0] DEFAULT_RESET_PC = 8'h00;

  function automatic logic is_two_byte(input logic [7:0] op);
    return op[TWO_BYTE_BIT];
  endfunction

endpackage

// File: rtl/fetch_unit.sv
// Fetches 1- or 2-byte instructions from a 256x8 sync memory into a hold reg.
// Optional macro FETCH_PERF_EN adds a saturating 16-bit transfer counter.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter logic [7:0] RESET_PC = DEFAULT_RESET_PC
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic [7:0]  mem_addr,
  output logic        mem_we,
  input  logic [7:0]  mem_rdata,
  input  logic        redirect,
  input  logic [7:0]  redirect_pc,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic [7:0]  instr_opcode,
  output logic [7:0]  instr_operand,
  output logic [7:0]  instr_pc
`ifdef FETCH_PERF_EN
  ,
  output logic [15:0] instr_count
`endif
);

  fetch_state_t r_state;
  fetch_state_t w_state_nxt;

  logic [7:0] r_pc;
  logic [7:0] w_pc_nxt;
  logic [7:0] w_pc_inc1;
  logic [7:0] w_pc_inc2;
  logic [7:0] w_addr;

  logic [7:0] r_opcode;
  logic [7:0] r_operand;
  logic [7:0] r_ipc;

  logic w_valid;
  logic w_xfer;
  logic w_cap_op;
  logic w_cap_opd;

  assign w_pc_inc1 = r_pc + 8'd1;
  assign w_pc_inc2 = r_pc + 8'd2;
  assign w_valid   = (r_state == S_HOLD);
  assign w_xfer    = w_valid && instr_ready;

  // State register; redirect and reset both restart at FETCH.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_FETCH;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next state, next PC, memory address and capture strobes.
  always_comb begin
    w_state_nxt = r_state;
    w_pc_nxt    = r_pc;
    w_addr      = r_pc;
    w_cap_op    = 1'b0;
    w_cap_opd   = 1'b0;
    case (r_state)
      S_FETCH: begin
        w_state_nxt = S_OPCODE;
      end
      S_OPCODE: begin
        w_addr   = w_pc_inc1;
        w_cap_op = 1'b1;
        if (is_two_byte(mem_rdata)) begin
          w_state_nxt = S_OPERAND;
        end else begin
          w_pc_nxt    = w_pc_inc1;
          w_state_nxt = S_HOLD;
        end
      end
      S_OPERAND: begin
        w_addr      = w_pc_inc1;
        w_cap_opd   = 1'b1;
        w_pc_nxt    = w_pc_inc2;
        w_state_nxt = S_HOLD;
      end
      S_HOLD: begin
        if (w_xfer) begin
          w_state_nxt = S_FETCH;
        end
      end
      default: begin
        w_state_nxt = S_FETCH;
      end
    endcase
    if (redirect) begin
      w_state_nxt = S_FETCH;
      w_pc_nxt    = redirect_pc;
      w_cap_op    = 1'b0;
      w_cap_opd   = 1'b0;
    end
  end

  // Program counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pc <= RESET_PC;
    end else begin
      r_pc <= w_pc_nxt;
    end
  end

  // Instruction hold registers; stable while waiting in HOLD.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_opcode  <= 8'h00;
      r_operand <= 8'h00;
      r_ipc     <= 8'h00;
    end else if (w_cap_op) begin
      r_opcode  <= mem_rdata;
      r_operand <= 8'h00;
      r_ipc     <= r_pc;
    end else if (w_cap_opd) begin
      r_operand <= mem_rdata;
    end
  end

`ifdef FETCH_PERF_EN
  logic [15:0] r_count;

  // Completed-transfer counter, saturating at all-ones.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count <= 16'h0000;
    end else if (w_xfer && (r_count != 16'hFFFF)) begin
      r_count <= r_count + 16'd1;
    end
  end

  assign instr_count = r_count;
`endif

  assign mem_addr      = w_addr;
  assign mem_we        = 1'b0;
  assign instr_valid   = w_valid;
  assign instr_opcode  = r_opcode;
  assign instr_operand = r_operand;
  assign instr_pc      = r_ipc;

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit against a transaction-level model.
// Build with +define+FETCH_PERF_EN to also check instr_count.
module tb_fetch_unit;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n;
  logic [7:0] mem_addr;
  logic       mem_we;
  logic [7:0] mem_rdata;
  logic       redirect;
  logic [7:0] redirect_pc;
  logic       instr_valid;
  logic       instr_ready;
  logic [7:0] instr_opcode;
  logic [7:0] instr_operand;
  logic [7:0] instr_pc;
`ifdef FETCH_PERF_EN
  logic [15:0] instr_count;
  logic [15:0] cnt2;
`endif

  logic [7:0] a2;
  logic       we2;
  logic [7:0] rd2;
  logic       v2;
  logic       rdy2 = 1'b1;
  logic       redir2 = 1'b0;
  logic [7:0] rpc2 = 8'h00;
  logic [7:0] op2;
  logic [7:0] opd2;
  logic [7:0] pc2;

  logic [7:0] mem  [256];
  logic [7:0] mem2 [256];

  fetch_unit dut (
    .clk(clk),
    .rst_n(rst_n),
    .mem_addr(mem_addr),
    .mem_we(mem_we),
    .mem_rdata(mem_rdata),
    .redirect(redirect),
    .redirect_pc(redirect_pc),
    .instr_valid(instr_valid),
    .instr_ready(instr_ready),
    .instr_opcode(instr_opcode),
    .instr_operand(instr_operand),
    .instr_pc(instr_pc)
`ifdef FETCH_PERF_EN
    ,
    .instr_count(instr_count)
`endif
  );

  fetch_unit #(.RESET_PC(8'hFF)) dut2 (
    .clk(clk),
    .rst_n(rst_n),
    .mem_addr(a2),
    .mem_we(we2),
    .mem_rdata(rd2),
    .redirect(redir2),
    .redirect_pc(rpc2),
    .instr_valid(v2),
    .instr_ready(rdy2),
    .instr_opcode(op2),
    .instr_operand(opd2),
    .instr_pc(pc2)
`ifdef FETCH_PERF_EN
    ,
    .instr_count(cnt2)
`endif
  );

  always @(posedge clk) begin
    mem_rdata <= mem[mem_addr];
    rd2       <= mem2[a2];
  end

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // model: pc of the instruction being fetched, cycles since restart
  logic [7:0]  m_pc;
  int          m_k;
  logic [15:0] m_cnt;

  // DUT-side observations for literal checks
  bit          dv;
  int          cyc_since;
  int          cur_lat;
  logic [7:0]  lg_op[$];
  logic [7:0]  lg_opd[$];
  logic [7:0]  lg_pc[$];
  int          lg_lat[$];

  function automatic bit m_two();
    logic [7:0] b;
    b = mem[m_pc];
    return b[7];
  endfunction

  function automatic bit m_valid();
    return m_k >= (m_two() ? 3 : 2);
  endfunction

  task automatic compare();
    bit         ev;
    logic [7:0] nx;
    logic [7:0] nxt_pc;
    ev     = m_valid();
    nx     = m_pc + 8'd1;
    nxt_pc = m_pc + (m_two() ? 8'd2 : 8'd1);
    chk("valid", 32'(instr_valid), 32'(ev));
    chk("mem_we", 32'(mem_we), 32'd0);
    if (ev) begin
      chk("opcode", 32'(instr_opcode), 32'(mem[m_pc]));
      chk("operand", 32'(instr_operand), m_two() ? 32'(mem[nx]) : 32'd0);
      chk("instr_pc", 32'(instr_pc), 32'(m_pc));
      chk("hold_addr", 32'(mem_addr), 32'(nxt_pc));
    end
    if (m_k == 0) chk("fetch_addr", 32'(mem_addr), 32'(m_pc));
    if (m_k == 1) chk("opc_addr", 32'(mem_addr), 32'(nx));
`ifdef FETCH_PERF_EN
    chk("count", 32'(instr_count), 32'(m_cnt));
`endif
    if (instr_valid && !dv) cur_lat = cyc_since;
    dv = instr_valid;
  endtask

  task automatic model_edge(input bit rdy, input bit rd,
                            input logic [7:0] rpc);
    bit         xf;
    logic [7:0] len;
    xf  = m_valid() && rdy;
    len = m_two() ? 8'd2 : 8'd1;
    if (xf && m_cnt != 16'hFFFF) m_cnt = m_cnt + 16'd1;
    if (rd) begin
      m_pc = rpc;
      m_k  = 0;
    end else if (xf) begin
      m_pc = m_pc + len;
      m_k  = 0;
    end else if (m_k < 7) begin
      m_k = m_k + 1;
    end
  endtask

  task automatic cycle(input bit rdy, input bit rd, input logic [7:0] rpc);
    bit xd;
    instr_ready = rdy;
    redirect    = rd;
    redirect_pc = rpc;
    xd = dv && rdy;
    if (xd) begin
      lg_op.push_back(instr_opcode);
      lg_opd.push_back(instr_operand);
      lg_pc.push_back(instr_pc);
      lg_lat.push_back(cur_lat);
    end
    @(posedge clk);
    model_edge(rdy, rd, rpc);
    cyc_since = (rd || xd) ? 0 : cyc_since + 1;
    @(negedge clk);
    compare();
  endtask

  task automatic rst_assert();
    rst_n       = 1'b0;
    instr_ready = 1'b0;
    redirect    = 1'b0;
    redirect_pc = 8'h00;
    #1;
    chk("rst_valid", 32'(instr_valid), 32'd0);
    chk("rst_op", 32'(instr_opcode), 32'd0);
    chk("rst_opd", 32'(instr_operand), 32'd0);
    chk("rst_ipc", 32'(instr_pc), 32'd0);
    chk("rst_addr", 32'(mem_addr), 32'h00);
    chk("rst2_addr", 32'(a2), 32'hFF);
    chk("rst2_valid", 32'(v2), 32'd0);
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic rst_release();
    rst_n     = 1'b1;
    m_pc      = 8'h00;
    m_k       = 0;
    m_cnt     = 16'h0000;
    dv        = 1'b0;
    cyc_since = 0;
    cur_lat   = 0;
    lg_op.delete();
    lg_opd.delete();
    lg_pc.delete();
    lg_lat.delete();
    compare();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    int n;
    rst_n       = 1'b0;
    instr_ready = 1'b0;
    redirect    = 1'b0;
    redirect_pc = 8'h00;
    for (int i = 0; i < 256; i++) begin
      mem[i]  = 8'(i + 1) & 8'h7F;
      mem2[i] = 8'h00;
    end
    mem2[8'hFF] = 8'h90;
    mem2[8'h00] = 8'h11;
    mem2[8'h01] = 8'h22;
    mem2[8'h02] = 8'h33;
    repeat (2) @(negedge clk);

    // one-byte stream, plus wraparound on the RESET_PC=FF instance
    rst_assert();
    rst_release();
    repeat (3) cycle(1'b1, 1'b0, 8'h00);
    chk("w_valid", 32'(v2), 32'd1);
    chk("w_op", 32'(op2), 32'h90);
    chk("w_opd", 32'(opd2), 32'h11);
    chk("w_pc", 32'(pc2), 32'hFF);
    repeat (3) cycle(1'b1, 1'b0, 8'h00);
    chk("w2_valid", 32'(v2), 32'd1);
    chk("w2_op", 32'(op2), 32'h22);
    chk("w2_opd", 32'(opd2), 32'h00);
    chk("w2_pc", 32'(pc2), 32'h01);
    repeat (4) cycle(1'b1, 1'b0, 8'h00);
    chk("t1_n", 32'(lg_op.size() >= 2), 32'd1);
    if (lg_op.size() >= 2) begin
      chk("t1_op0", 32'(lg_op[0]), 32'h01);
      chk("t1_pc0", 32'(lg_pc[0]), 32'h00);
      chk("t1_opd0", 32'(lg_opd[0]), 32'h00);
      chk("t1_lat0", 32'(lg_lat[0]), 32'd2);
      chk("t1_op1", 32'(lg_op[1]), 32'h02);
      chk("t1_pc1", 32'(lg_pc[1]), 32'h01);
    end

    // two-byte instruction
    rst_assert();
    mem[0] = 8'h85;
    mem[1] = 8'hAA;
    mem[2] = 8'h07;
    rst_release();
    repeat (8) cycle(1'b1, 1'b0, 8'h00);
    chk("t2_n", 32'(lg_op.size() >= 2), 32'd1);
    if (lg_op.size() >= 2) begin
      chk("t2_op0", 32'(lg_op[0]), 32'h85);
      chk("t2_opd0", 32'(lg_opd[0]), 32'hAA);
      chk("t2_pc0", 32'(lg_pc[0]), 32'h00);
      chk("t2_lat0", 32'(lg_lat[0]), 32'd3);
      chk("t2_pc1", 32'(lg_pc[1]), 32'h02);
      chk("t2_op1", 32'(lg_op[1]), 32'h07);
    end

    // back-pressure in HOLD
    rst_assert();
    rst_release();
    n = 0;
    while (!dv && n < 10) begin
      cycle(1'b0, 1'b0, 8'h00);
      n++;
    end
    chk("t3_reached", 32'(dv), 32'd1);
    repeat (5) cycle(1'b0, 1'b0, 8'h00);
    chk("t3_valid", 32'(instr_valid), 32'd1);
    chk("t3_op", 32'(instr_opcode), 32'h85);
    chk("t3_opd", 32'(instr_operand), 32'hAA);
    chk("t3_none", 32'(lg_op.size()), 32'd0);
    cycle(1'b1, 1'b0, 8'h00);
    repeat (3) cycle(1'b0, 1'b0, 8'h00);
    chk("t3_one", 32'(lg_op.size()), 32'd1);

    // redirect in OPERAND, then redirect together with a transfer
    rst_assert();
    mem[8'h40] = 8'h12;
    mem[8'h50] = 8'hC1;
    mem[8'h51] = 8'h5A;
    rst_release();
    repeat (2) cycle(1'b1, 1'b0, 8'h00);
    cycle(1'b1, 1'b1, 8'h40);
    repeat (2) cycle(1'b1, 1'b0, 8'h00);
    chk("t4_valid", 32'(instr_valid), 32'd1);
    chk("t4_pc", 32'(instr_pc), 32'h40);
    chk("t4_op", 32'(instr_opcode), 32'h12);
    cycle(1'b1, 1'b1, 8'h50);
    repeat (3) cycle(1'b1, 1'b0, 8'h00);
    chk("t4_n", 32'(lg_pc.size()), 32'd1);
    if (lg_pc.size() >= 1) chk("t4_lg_pc", 32'(lg_pc[0]), 32'h40);
    chk("t4b_valid", 32'(instr_valid), 32'd1);
    chk("t4b_pc", 32'(instr_pc), 32'h50);
    chk("t4b_op", 32'(instr_opcode), 32'hC1);
    chk("t4b_opd", 32'(instr_operand), 32'h5A);
`ifdef FETCH_PERF_EN
    chk("t4_count", 32'(instr_count), 32'd1);
`endif

    // randomized traffic
    rst_assert();
    for (int i = 0; i < 256; i++) mem[i] = 8'($urandom);
    rst_release();
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 999) < 3) begin
        rst_assert();
        rst_release();
      end else begin
        cycle($urandom_range(0, 9) < 7,
              $urandom_range(0, 19) == 0,
              8'($urandom));
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
